// File: rtl/mips_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : mips_pipe_pkg
//  Purpose  : Shared types and constants for the MIPS-like pipeline stages.
//  Revision : 1.0 - initial release
// ============================================================================
package mips_pipe_pkg;

  localparam int c_data_w    = 16;
  localparam int c_reg_sel_w = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_HALTED = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic                   reg_write;
    logic                   halt;
    logic                   err;
    logic [c_reg_sel_w-1:0] target;
    logic [c_reg_sel_w-1:0] sel;
    logic [c_data_w-1:0]    alu_data;
    logic [c_data_w-1:0]    mem_data;
    logic [c_data_w-1:0]    next_pc;
  } mem_wb_t;

  localparam mem_wb_t c_mw_bubble = '0;

  // Error bubble: nothing written back, but the halt/err flags travel to WB.
  localparam mem_wb_t c_mw_err = '{1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 16'd0, 16'd0, 16'd0};

endpackage
`default_nettype wire

// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
//  Interface : mem_stage_if
//  Purpose   : Req/done handshake between the MEM stage and data memory.
//  Revision  : 1.0 - initial release
// ============================================================================
interface mem_stage_if;
  import mips_pipe_pkg::*;

  logic                mem_req;
  logic                mem_wr;
  logic [c_data_w-1:0] mem_addr;
  logic [c_data_w-1:0] mem_wdata;
  logic                mem_done;
  logic [c_data_w-1:0] mem_rdata;

  modport master (
    output mem_req, mem_wr, mem_addr, mem_wdata,
    input  mem_done, mem_rdata
  );

  modport slave (
    input  mem_req, mem_wr, mem_addr, mem_wdata,
    output mem_done, mem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/register16.sv
`default_nettype none
// ============================================================================
//  Module   : register16
//  Purpose  : Pipeline latch field with synchronous active-high clear.
//  Revision : 1.0 - initial release
// ============================================================================
module register16 #(
  parameter int SIZE = 16
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic [SIZE-1:0] i_d,
  output logic      [SIZE-1:0] o_q
);

  always_ff @(posedge clk) begin
    if (rst) o_q <= '0;
    else     o_q <= i_d;
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Purpose  : Pipeline MEM stage: variable-latency loads/stores, upstream
//             stall, misalign/timeout error halt, MEM/WB latch.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stage
  import mips_pipe_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic                   reg_write,
  input  wire logic                   halt_XM,
  input  wire logic                   mem_read_XM,
  input  wire logic                   mem_write_XM,
  input  wire logic [c_reg_sel_w-1:0] target_WBreg_XM,
  input  wire logic [c_reg_sel_w-1:0] Sel_WBreg_XM,
  input  wire logic [c_data_w-1:0]    alu_data,
  input  wire logic [c_data_w-1:0]    Data2_XM,
  input  wire logic [c_data_w-1:0]    nextPC_XM,
  mem_stage_if.master                 mem_bus,
  output logic                        stall_mem,
  output logic                        reg_write_MW,
  output logic                        halt_MW,
  output logic                        err_MW,
  output logic      [c_reg_sel_w-1:0] target_WBreg_MW,
  output logic      [c_reg_sel_w-1:0] Sel_WBreg_MW,
  output logic      [c_data_w-1:0]    alu_data_MW,
  output logic      [c_data_w-1:0]    mem_data_MW,
  output logic      [c_data_w-1:0]    nextPC_MW
);

  localparam logic [7:0] c_max_wait = 8'(MAX_WAIT);

  mem_state_t r_state;
  mem_state_t w_next_state;
  logic [7:0] r_wait_cnt;
  logic [7:0] w_wait_cnt_next;
  logic [7:0] w_wait_cnt_inc;
  logic       w_access;
  logic       w_misaligned;
  logic       w_timeout;
  logic       w_mem_req;
  logic       w_bubble;
  logic       w_clear;
  mem_wb_t    w_mw_d;

  assign w_access     = mem_read_XM | mem_write_XM;
  assign w_misaligned = w_access & alu_data[0];

  assign mem_bus.mem_req   = w_mem_req;
  assign mem_bus.mem_wr    = mem_write_XM;
  assign mem_bus.mem_addr  = alu_data;
  assign mem_bus.mem_wdata = Data2_XM;

  // Counter saturates so a large MAX_WAIT can never wrap past the limit.
  assign w_wait_cnt_inc = (r_wait_cnt == 8'hFF) ? r_wait_cnt : r_wait_cnt + 8'd1;
  assign w_timeout      = (r_state == ST_WAIT) && !mem_bus.mem_done &&
                          (w_wait_cnt_inc >= c_max_wait);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_cnt_next;
    end
  end

  always_comb begin
    w_next_state    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_access) begin
          if (w_misaligned) begin
            w_next_state = ST_HALTED;
          end else if (!mem_bus.mem_done) begin
            w_next_state    = ST_WAIT;
            w_wait_cnt_next = '0;
          end
        end else if (halt_XM) begin
          w_next_state = ST_HALTED;
        end
      end
      ST_WAIT: begin
        if (mem_bus.mem_done)  w_next_state = ST_IDLE;
        else if (w_timeout)    w_next_state = ST_HALTED;
        else                   w_wait_cnt_next = w_wait_cnt_inc;
      end
      ST_HALTED: w_next_state = ST_HALTED;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_mem_req = 1'b0;
    stall_mem = 1'b0;
    w_bubble  = 1'b0;
    w_mw_d    = c_mw_bubble;
    w_mw_d.reg_write = reg_write;
    w_mw_d.halt      = halt_XM;
    w_mw_d.target    = target_WBreg_XM;
    w_mw_d.sel       = Sel_WBreg_XM;
    w_mw_d.alu_data  = alu_data;
    w_mw_d.next_pc   = nextPC_XM;
    // Completed loads carry read data; stores and ALU ops carry zero.
    if (w_access && !mem_write_XM) w_mw_d.mem_data = mem_bus.mem_rdata;
    case (r_state)
      ST_IDLE: begin
        if (w_misaligned) begin
          w_mw_d = c_mw_err;
        end else if (w_access) begin
          w_mem_req = 1'b1;
          if (!mem_bus.mem_done) begin
            stall_mem = 1'b1;
            w_bubble  = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        w_mem_req = 1'b1;
        if (!mem_bus.mem_done) begin
          stall_mem = 1'b1;
          if (w_timeout) w_mw_d   = c_mw_err;
          else           w_bubble = 1'b1;
        end
      end
      default: begin
        stall_mem = 1'b1;
        w_bubble  = 1'b1;
      end
    endcase
  end

  assign w_clear = ~rst | w_bubble;

  register16 #(.SIZE(1)) u_reg_write (
    .clk(clk), .rst(w_clear), .i_d(w_mw_d.reg_write), .o_q(reg_write_MW)
  );
  register16 #(.SIZE(1)) u_halt (
    .clk(clk), .rst(w_clear), .i_d(w_mw_d.halt), .o_q(halt_MW)
  );
  register16 #(.SIZE(1)) u_err (
    .clk(clk), .rst(w_clear), .i_d(w_mw_d.err), .o_q(err_MW)
  );
  register16 #(.SIZE(c_reg_sel_w)) u_target (
    .clk(clk), .rst(w_clear), .i_d(w_mw_d.target), .o_q(target_WBreg_MW)
  );
  register16 #(.SIZE(c_reg_sel_w)) u_sel (
    .clk(clk), .rst(w_clear), .i_d(w_mw_d.sel), .o_q(Sel_WBreg_MW)
  );
  register16 #(.SIZE(c_data_w)) u_alu_data (
    .clk(clk), .rst(w_clear), .i_d(w_mw_d.alu_data), .o_q(alu_data_MW)
  );
  register16 #(.SIZE(c_data_w)) u_mem_data (
    .clk(clk), .rst(w_clear), .i_d(w_mw_d.mem_data), .o_q(mem_data_MW)
  );
  register16 #(.SIZE(c_data_w)) u_next_pc (
    .clk(clk), .rst(w_clear), .i_d(w_mw_d.next_pc), .o_q(nextPC_MW)
  );

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage
//  Purpose  : Directed self-checking bench for mem_stage (MAX_WAIT = 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_write, halt_XM, mem_read_XM, mem_write_XM;
  logic [2:0]  target_WBreg_XM, Sel_WBreg_XM;
  logic [15:0] alu_data, Data2_XM, nextPC_XM;
  logic        stall_mem, reg_write_MW, halt_MW, err_MW;
  logic [2:0]  target_WBreg_MW, Sel_WBreg_MW;
  logic [15:0] alu_data_MW, mem_data_MW, nextPC_MW;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage_if bus ();

  mem_stage #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .reg_write(reg_write), .halt_XM(halt_XM),
    .mem_read_XM(mem_read_XM), .mem_write_XM(mem_write_XM),
    .target_WBreg_XM(target_WBreg_XM), .Sel_WBreg_XM(Sel_WBreg_XM),
    .alu_data(alu_data), .Data2_XM(Data2_XM), .nextPC_XM(nextPC_XM),
    .mem_bus(bus),
    .stall_mem(stall_mem),
    .reg_write_MW(reg_write_MW), .halt_MW(halt_MW), .err_MW(err_MW),
    .target_WBreg_MW(target_WBreg_MW), .Sel_WBreg_MW(Sel_WBreg_MW),
    .alu_data_MW(alu_data_MW), .mem_data_MW(mem_data_MW), .nextPC_MW(nextPC_MW)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_op(input logic rw, input logic hlt, input logic mr, input logic mw,
                        input logic [2:0] tgt, input logic [2:0] sl,
                        input logic [15:0] alu, input logic [15:0] d2, input logic [15:0] npc);
    reg_write = rw;  halt_XM = hlt;  mem_read_XM = mr;  mem_write_XM = mw;
    target_WBreg_XM = tgt;  Sel_WBreg_XM = sl;
    alu_data = alu;  Data2_XM = d2;  nextPC_XM = npc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
    bus.mem_done  = 1'b0;
    bus.mem_rdata = 16'h0;
    step();
    step();
    rst = 1'b1;
  endtask

  initial begin
    do_reset();
    check_val("rst_rw",    {31'd0, reg_write_MW}, 32'd0);
    check_val("rst_halt",  {31'd0, halt_MW},      32'd0);
    check_val("rst_err",   {31'd0, err_MW},       32'd0);
    check_val("rst_alu",   {16'd0, alu_data_MW},  32'd0);
    check_val("rst_npc",   {16'd0, nextPC_MW},    32'd0);
    check_val("rst_req",   {31'd0, bus.mem_req},  32'd0);
    check_val("rst_stall", {31'd0, stall_mem},    32'd0);

    // ALU op passes through in one cycle
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 3'd1, 16'h1234, 16'h0, 16'h0102);
    #2;
    check_val("alu_stall", {31'd0, stall_mem},   32'd0);
    check_val("alu_req",   {31'd0, bus.mem_req}, 32'd0);
    step();
    check_val("alu_data",  {16'd0, alu_data_MW},     32'h1234);
    check_val("alu_rw",    {31'd0, reg_write_MW},    32'd1);
    check_val("alu_tgt",   {29'd0, target_WBreg_MW}, 32'd3);
    check_val("alu_sel",   {29'd0, Sel_WBreg_MW},    32'd1);
    check_val("alu_npc",   {16'd0, nextPC_MW},       32'h0102);
    check_val("alu_mdata", {16'd0, mem_data_MW},     32'd0);

    // Load at 0x0040, done 3 cycles after the request cycle
    set_op(1'b1, 1'b0, 1'b1, 1'b0, 3'd5, 3'd2, 16'h0040, 16'h0, 16'h0022);
    for (int i = 0; i < 4; i++) begin
      bus.mem_done  = (i == 3);
      bus.mem_rdata = (i == 3) ? 16'hBEEF : 16'h0;
      #2;
      check_val("ld_stall", {31'd0, stall_mem},   {31'd0, (i < 3)});
      check_val("ld_req",   {31'd0, bus.mem_req}, 32'd1);
      check_val("ld_addr",  {16'd0, bus.mem_addr}, 32'h0040);
      step();
      if (i < 3) check_val("ld_bubble", {31'd0, reg_write_MW}, 32'd0);
    end
    check_val("ld_data", {16'd0, mem_data_MW},     32'hBEEF);
    check_val("ld_rw",   {31'd0, reg_write_MW},    32'd1);
    check_val("ld_tgt",  {29'd0, target_WBreg_MW}, 32'd5);
    check_val("ld_npc",  {16'd0, nextPC_MW},       32'h0022);
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
    bus.mem_done = 1'b0;
    bus.mem_rdata = 16'h0;
    step();
    check_val("ld_once",  {31'd0, reg_write_MW}, 32'd0);
    check_val("ld_after", {31'd0, stall_mem},    32'd0);

    // Zero-wait store
    set_op(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 16'h0010, 16'hA5A5, 16'h0030);
    bus.mem_done = 1'b1;
    #2;
    check_val("st_req",   {31'd0, bus.mem_req},   32'd1);
    check_val("st_wr",    {31'd0, bus.mem_wr},    32'd1);
    check_val("st_wdata", {16'd0, bus.mem_wdata}, 32'hA5A5);
    check_val("st_stall", {31'd0, stall_mem},     32'd0);
    step();
    check_val("st_rw",    {31'd0, reg_write_MW},  32'd0);
    check_val("st_mdata", {16'd0, mem_data_MW},   32'd0);
    check_val("st_alu",   {16'd0, alu_data_MW},   32'h0010);
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
    bus.mem_done = 1'b0;
    #2;
    check_val("st_req_off", {31'd0, bus.mem_req}, 32'd0);
    step();

    // Done on the 4th WAIT cycle (counter limit reached): done wins
    set_op(1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 3'd2, 16'h0060, 16'h0, 16'h0);
    for (int i = 0; i < 5; i++) begin
      bus.mem_done  = (i == 4);
      bus.mem_rdata = (i == 4) ? 16'h1357 : 16'h0;
      #2;
      check_val("lim_stall", {31'd0, stall_mem}, {31'd0, (i < 4)});
      step();
    end
    check_val("lim_err",  {31'd0, err_MW},       32'd0);
    check_val("lim_data", {16'd0, mem_data_MW},  32'h1357);
    check_val("lim_rw",   {31'd0, reg_write_MW}, 32'd1);
    bus.mem_done = 1'b0;
    bus.mem_rdata = 16'h0;

    // Timeout: no done, stall for MAX_WAIT+1 cycles then error
    set_op(1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 3'd2, 16'h0080, 16'h0, 16'h0);
    for (int i = 0; i < 5; i++) begin
      #2;
      check_val("to_stall", {31'd0, stall_mem},   32'd1);
      check_val("to_req",   {31'd0, bus.mem_req}, 32'd1);
      step();
      if (i < 4) check_val("to_early_err", {31'd0, err_MW}, 32'd0);
    end
    check_val("to_err",  {31'd0, err_MW},       32'd1);
    check_val("to_halt", {31'd0, halt_MW},      32'd1);
    check_val("to_rw",   {31'd0, reg_write_MW}, 32'd0);
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
    #2;
    check_val("to_hstall", {31'd0, stall_mem},   32'd1);
    check_val("to_hreq",   {31'd0, bus.mem_req}, 32'd0);
    step();
    check_val("to_pulse", {31'd0, err_MW}, 32'd0);
    do_reset();

    // Misaligned load: no request, immediate error, then halted
    set_op(1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 3'd2, 16'h0041, 16'h0, 16'h0);
    #2;
    check_val("mis_req", {31'd0, bus.mem_req}, 32'd0);
    step();
    check_val("mis_err",  {31'd0, err_MW},       32'd1);
    check_val("mis_halt", {31'd0, halt_MW},      32'd1);
    check_val("mis_rw",   {31'd0, reg_write_MW}, 32'd0);
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 3'd0, 16'h7777, 16'h0, 16'h0);
    #2;
    check_val("mis_hstall", {31'd0, stall_mem},   32'd1);
    check_val("mis_hreq",   {31'd0, bus.mem_req}, 32'd0);
    step();
    check_val("mis_ignore", {16'd0, alu_data_MW}, 32'd0);
    check_val("mis_pulse",  {31'd0, err_MW},      32'd0);
    do_reset();

    // Reset in the middle of WAIT aborts the access
    set_op(1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 3'd2, 16'h0020, 16'h0, 16'h0);
    step();
    #2;
    check_val("rw_req", {31'd0, bus.mem_req}, 32'd1);
    step();
    rst = 1'b0;
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
    step();
    check_val("rw_req_off", {31'd0, bus.mem_req},  32'd0);
    check_val("rw_stall",   {31'd0, stall_mem},    32'd0);
    check_val("rw_rw",      {31'd0, reg_write_MW}, 32'd0);
    rst = 1'b1;
    bus.mem_done  = 1'b1;
    bus.mem_rdata = 16'hDEAD;
    #2;
    check_val("rw_late_req", {31'd0, bus.mem_req}, 32'd0);
    step();
    check_val("rw_late_data", {16'd0, mem_data_MW}, 32'd0);
    bus.mem_done  = 1'b0;
    bus.mem_rdata = 16'h0;
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 3'd6, 3'd0, 16'h5678, 16'h0, 16'h0);
    step();
    check_val("rw_alu", {16'd0, alu_data_MW},  32'h5678);
    check_val("rw_arw", {31'd0, reg_write_MW}, 32'd1);

    // Halt instruction: one-cycle halt pulse, then frozen
    set_op(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0044);
    step();
    check_val("hlt_halt", {31'd0, halt_MW},   32'd1);
    check_val("hlt_npc",  {16'd0, nextPC_MW}, 32'h0044);
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
    #2;
    check_val("hlt_stall", {31'd0, stall_mem}, 32'd1);
    step();
    check_val("hlt_pulse", {31'd0, halt_MW}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory stage of the 5-stage MIPS-like pipeline: consumes EX/MEM latch outputs, performs loads and stores against a variable-latency data memory through a req/done handshake, and registers results into the MEM/WB latch. While an access is outstanding it raises `stall_mem` to freeze Fetch through EX/MEM. It also turns misaligned accesses and memory timeouts into an error halt.

## Interface
Parameters:
- `MAX_WAIT`, 15, cycles in WAIT without `mem_done` before timeout error (1..255)

Ports:
- `clk` in 1: clock, rising edge
- `rst` in 1: reset, synchronous, active-low
- `reg_write`, `halt_XM`, `mem_read_XM`, `mem_write_XM` in 1 each: EX/MEM control
- `target_WBreg_XM`, `Sel_WBreg_XM` in 3 each: dest register, WB mux select
- `alu_data` in 16: ALU result / memory byte address
- `Data2_XM` in 16: store data
- `nextPC_XM` in 16: PC+2, for link writes
- `mem_req` out 1: access request
- `mem_wr` out 1: 1 = store, 0 = load
- `mem_addr`, `mem_wdata` out 16 each
- `mem_done` in 1: access complete, one-cycle pulse
- `mem_rdata` in 16: load data, valid with `mem_done`
- `stall_mem` out 1: freeze all upstream stages and EX/MEM
- `reg_write_MW`, `halt_MW`, `err_MW` out 1 each
- `target_WBreg_MW`, `Sel_WBreg_MW` out 3 each
- `alu_data_MW`, `mem_data_MW`, `nextPC_MW` out 16 each

## Operation
- Access op = `mem_read_XM | mem_write_XM`. Both set: treated as store.
- Misaligned = access op with `alu_data[0]=1`. No request issued.
- `mem_addr` = `alu_data`, `mem_wdata` = `Data2_XM`, `mem_wr` = `mem_write_XM`. All combinational from inputs, valid whenever `mem_req=1`.
- FSM states: IDLE, WAIT, HALTED.
- IDLE, non-access op: no request. MEM/WB loads inputs. `mem_data_MW` loads 0.
- IDLE, aligned access: `mem_req=1`.
  - If `mem_done` is high the same cycle: complete, no stall, stay IDLE.
  - Otherwise: `stall_mem=1`, go to WAIT, wait counter cleared.
- WAIT: `mem_req=1`, `stall_mem=1`. Inputs are stable because upstream is frozen. Counter increments each cycle.
  - On `mem_done`: `stall_mem=0` that cycle, MEM/WB loads inputs plus `mem_rdata` (stores load 0), go to IDLE.
  - If the counter reaches `MAX_WAIT` without `mem_done`: error exit.
- Error exit (misaligned or timeout): no memory write. MEM/WB loads a bubble with `err_MW=1`, `halt_MW=1`, `reg_write_MW=0`. Go to HALTED.
- `halt_XM=1` op (non-access): passes to MEM/WB with `halt_MW=1`. Go to HALTED.
- HALTED:
  - `mem_req=0`, `stall_mem=1`.
  - MEM/WB loads a bubble (all zero) each cycle, so `halt_MW` and `err_MW` are one-cycle pulses.
  - Inputs are ignored. Exit only by reset.
- Stall cycles: MEM/WB loads a bubble (all fields 0), so no duplicate writeback occurs.
- `mem_done` outside an active request is ignored.

## Timing
- Reset (`rst=0` at a clock edge):
  - state IDLE, counter 0
  - all MEM/WB outputs 0
  - `mem_req` and `stall_mem` are 0 combinationally while IDLE with zero inputs
- Reset during WAIT aborts the access: `mem_req` is 0 in the cycle after the edge. A late `mem_done` is ignored.
- Non-access op or zero-wait access: 1-cycle latency from EX/MEM to MEM/WB.
- Access completing N cycles after request (`mem_done` N cycles after the IDLE cycle):
  - `stall_mem` high for N cycles
  - result appears in MEM/WB at the edge ending the done cycle
- Timeout:
  - `stall_mem` high for `MAX_WAIT+1` cycles (IDLE cycle plus `MAX_WAIT` WAIT cycles)
  - `err_MW` asserts at the following edge
- Counter is 8 bits and saturates. It never wraps.
- `mem_done` arriving in the same cycle the counter hits `MAX_WAIT`: done wins.

## Structure
- Shared package `mips_pipe_pkg`:
  - state enum (IDLE/WAIT/HALTED)
  - 16-bit data width and 3-bit register-select width constants
  - MEM/WB bubble constant
- MEM/WB latch built from the existing `register16` (SIZE parameterised) instances, one per field. The `rst` input is driven from an internal active-high clear = `~rst | bubble`.
- FSM and wait counter inline. No further sub-modules.

## Test plan
- ALU op, `alu_data=0x1234`, `reg_write=1`, target 3 -> next cycle `alu_data_MW=0x1234`, `reg_write_MW=1`, `stall_mem=0` throughout.
- Load at 0x0040, `mem_done` 3 cycles later with `mem_rdata=0xBEEF` -> `stall_mem` high 3 cycles, then `mem_data_MW=0xBEEF`, one writeback only.
- Store at 0x0010, data 0xA5A5, zero-wait `mem_done` -> `mem_req`/`mem_wr` high one cycle, `mem_wdata=0xA5A5`, no stall, `reg_write_MW=0`.
- Load at 0x0041 -> `mem_req` never asserts, next cycle `err_MW=1` and `halt_MW=1`, then HALTED with `stall_mem=1` until reset.
- Load with no `mem_done`, `MAX_WAIT=4` -> stall 5 cycles, then `err_MW=1`. Separately, `mem_done` at exactly the 4th WAIT cycle -> normal completion, no error.
- Reset asserted mid-WAIT -> `mem_req=0` and all outputs 0 the next cycle. A subsequent ALU op completes normally.
